// File: rtl/alu32_wb.sv
// rtl/alu32_wb.sv - ALU result write-back buffer: FIFO of {result, flags, opcode} with optional sticky flags
// Optional sticky flag accumulator enabled by defining ALU32_WB_STICKY_FLAGS_EN.
module alu32_wb #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_out,
  input  logic [3:0]               in_S,
  input  logic [4:0]               in_opCode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_data,
  output logic [3:0]               out_S,
  output logic [4:0]               out_opCode,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_sticky,
  output logic [3:0]               sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [N-1:0]    mem_data [DEPTH];
  logic [3:0]      mem_s    [DEPTH];
  logic [4:0]      mem_op   [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;

  // Handshakes depend only on the registered occupancy, so a full buffer
  // refuses a push even when a pop frees a slot in the same cycle.
  assign in_ready  = (cnt < FULL_CNT);
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt;

  assign out_data   = mem_data[rptr];
  assign out_S      = mem_s[rptr];
  assign out_opCode = mem_op[rptr];

  // Storage is reset so the head fields read as zero rather than X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_s[i]    <= '0;
        mem_op[i]   <= '0;
      end
    end else if (push) begin
      mem_data[wptr] <= in_out;
      mem_s[wptr]    <= in_S;
      mem_op[wptr]   <= in_opCode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef ALU32_WB_STICKY_FLAGS_EN
  logic [3:0] sticky_q;

  // A push coinciding with a clear restarts accumulation from that push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 4'h0;
    end else if (clr_sticky) begin
      sticky_q <= push ? in_S : 4'h0;
    end else if (push) begin
      sticky_q <= sticky_q | in_S;
    end
  end

  assign sticky = sticky_q;
`else
  logic unused_clr_sticky;

  assign unused_clr_sticky = clr_sticky;
  assign sticky            = 4'h0;
`endif

endmodule

// File: tb/tb_alu32_wb.sv
// tb/tb_alu32_wb.sv - directed self-checking bench for alu32_wb
module tb_alu32_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_out;
  logic [3:0]  in_S;
  logic [4:0]  in_opCode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_S;
  logic [4:0]  out_opCode;
  logic [2:0]  count;
  logic        clr_sticky;
  logic [3:0]  sticky;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ALU32_WB_STICKY_FLAGS_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  alu32_wb #(.N(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_out     (in_out),
    .in_S       (in_S),
    .in_opCode  (in_opCode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_S      (out_S),
    .out_opCode (out_opCode),
    .count      (count),
    .clr_sticky (clr_sticky),
    .sticky     (sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".count"},     32'(count),      32'd0);
    check({tag, ".out_valid"}, 32'(out_valid),  32'd0);
    check({tag, ".in_ready"},  32'(in_ready),   32'd1);
    check({tag, ".out_data"},  out_data,        32'd0);
    check({tag, ".out_S"},     32'(out_S),      32'd0);
    check({tag, ".out_op"},    32'(out_opCode), 32'd0);
    check({tag, ".sticky"},    32'(sticky),     32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_out     = '0;
    in_S       = '0;
    in_opCode  = '0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    #3;
    check_reset_state("rst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check_reset_state("rst_release");
    tick();

    // Single push, first-entry latency
    in_valid = 1'b1; in_out = 32'h9; in_S = 4'h0; in_opCode = 5'h0;
    tick();
    in_valid = 1'b0;
    check("single.out_valid", 32'(out_valid), 32'd1);
    check("single.out_data",  out_data,       32'h9);
    check("single.count",     32'(count),     32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single.drained", 32'(out_valid), 32'd0);

    // Fill to full
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_out = 32'(i); in_S = 4'(i); in_opCode = 5'(i + 16);
      tick();
    end
    check("full.count",    32'(count),      32'd4);
    check("full.in_ready", 32'(in_ready),   32'd0);
    check("full.head",     out_data,        32'h1);
    check("full.head_S",   32'(out_S),      32'h1);
    check("full.head_op",  32'(out_opCode), 32'h11);
    in_out = 32'h5; in_S = 4'h5; in_opCode = 5'h15;
    tick();
    check("full.ignored_count", 32'(count), 32'd4);
    check("full.ignored_head",  out_data,   32'h1);
    // Full with simultaneous pop: pop happens, push still refused
    out_ready = 1'b1;
    tick();
    check("full_pop.count", 32'(count), 32'd3);
    in_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      check("drain.data", out_data,        32'(i));
      check("drain.S",    32'(out_S),      32'(i));
      check("drain.op",   32'(out_opCode), 32'(i + 16));
      tick();
    end
    check("drain.out_valid", 32'(out_valid), 32'd0);
    check("drain.count",     32'(count),     32'd0);
    // Pop on empty is ignored
    tick();
    check("empty_pop.count", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Steady-state push+pop at count=2 with pointer wrap
    in_valid = 1'b1; in_S = 4'h0; in_opCode = 5'h1;
    in_out = 32'd100; tick();
    in_out = 32'd101; tick();
    check("stream.count0", 32'(count), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_out = 32'(102 + i);
      check("stream.data", out_data, 32'(100 + i));
      tick();
      check("stream.count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    check("stream.tail0", out_data, 32'd110);
    tick();
    check("stream.tail1", out_data, 32'd111);
    tick();
    check("stream.empty", 32'(out_valid), 32'd0);

    // Sticky flags: C|V, Z, N accumulate; clear with push restarts
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    check("sticky.cleared", 32'(sticky), 32'h0);
    in_valid = 1'b1;
    in_out = 32'hffff_fffe; in_S = 4'h3; in_opCode = 5'h2; tick();
    check("sticky.cv", 32'(sticky), STICKY_EN ? 32'h3 : 32'h0);
    check("flags.unmodified", 32'(out_S), 32'h3);
    in_out = 32'h0;         in_S = 4'h4; tick();
    in_out = 32'h8000_0004; in_S = 4'h8; tick();
    check("sticky.all", 32'(sticky), STICKY_EN ? 32'hF : 32'h0);
    clr_sticky = 1'b1; in_out = 32'h0; in_S = 4'h4; tick();
    check("sticky.clr_push", 32'(sticky), STICKY_EN ? 32'h4 : 32'h0);
    in_valid = 1'b0; tick();
    check("sticky.clr_only", 32'(sticky), 32'h0);
    clr_sticky = 1'b0;
    tick();
    check("sticky.drained", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Asynchronous reset between edges with count=3
    in_valid = 1'b1; in_S = 4'h0; in_opCode = 5'h3;
    for (int i = 0; i < 3; i++) begin
      in_out = 32'(32'h50 + i);
      tick();
    end
    in_valid = 1'b0;
    check("prereset.count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1 check_reset_state("async_rst");
    tick();
    #2 rst_n = 1'b1;
    #1 check_reset_state("post_rst");
    tick();
    in_valid = 1'b1; in_out = 32'h77; in_S = 4'h9; in_opCode = 5'h7;
    tick();
    in_valid = 1'b0;
    check("after_rst.count", 32'(count),      32'd1);
    check("after_rst.data",  out_data,        32'h77);
    check("after_rst.S",     32'(out_S),      32'h9);
    check("after_rst.op",    32'(out_opCode), 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
